// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter between the in-order pipeline writeback and a
// long-latency unit whose results wait in a small in-order queue.
module wb_port_arbiter #(
    parameter int DATA_W       = 32,
    parameter int RADDR_W      = 5,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       pipe_we_i,
    input  logic [RADDR_W-1:0]         pipe_rd_i,
    input  logic [DATA_W-1:0]          pipe_data_i,
    input  logic                       llu_valid_i,
    input  logic [RADDR_W-1:0]         llu_rd_i,
    input  logic [DATA_W-1:0]          llu_data_i,
    output logic                       llu_ready_o,
    output logic                       stall_o,
    output logic                       rf_we_o,
    output logic [RADDR_W-1:0]         rf_waddr_o,
    output logic [DATA_W-1:0]          rf_wdata_o,
    output logic [$clog2(DEPTH+1)-1:0] llu_pending_o
);

    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {NORMAL, FORCE} state_t;

    state_t              state, state_nxt;
    logic                q_live [DEPTH];
    logic [RADDR_W-1:0]  q_rd   [DEPTH];
    logic [DATA_W-1:0]   q_data [DEPTH];
    logic [PTR_W-1:0]    rd_ptr, wr_ptr;
    logic [CNT_W-1:0]    count;
    logic [WAIT_W-1:0]   wait_cnt, wait_nxt;

    logic q_empty, head_live, head_dead, push, pipe_req;
    logic grant_pipe, grant_head, pop, push_killed;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign q_empty     = (count == '0);
    assign head_live   = ~q_empty & q_live[rd_ptr];
    assign head_dead   = ~q_empty & ~q_live[rd_ptr];
    assign llu_ready_o = (count < CNT_W'(DEPTH));
    assign push        = llu_valid_i & llu_ready_o & (llu_rd_i != '0);
    assign stall_o     = (state == FORCE);
    assign pipe_req    = pipe_we_i & (pipe_rd_i != '0) & ~stall_o;
    // The pipe write is younger than any queued LLU result, so it wins the WAW race.
    assign push_killed = grant_pipe & (llu_rd_i == pipe_rd_i);
    assign llu_pending_o = count;

    always_comb begin
        grant_pipe = 1'b0;
        grant_head = 1'b0;
        pop        = 1'b0;
        state_nxt  = state;
        wait_nxt   = wait_cnt;
        case (state)
            NORMAL: begin
                grant_pipe = pipe_req;
                grant_head = ~pipe_req & head_live;
                pop        = grant_head | head_dead;
                if (head_live && !grant_head && wait_cnt == WAIT_W'(STARVE_LIMIT - 1))
                    state_nxt = FORCE;
            end
            FORCE: begin
                grant_head = head_live;
                pop        = ~q_empty;
                state_nxt  = NORMAL;
            end
            default: state_nxt = NORMAL;
        endcase
        if (pop || q_empty)
            wait_nxt = '0;
        else if (head_live && !grant_head)
            wait_nxt = wait_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= NORMAL;
            wait_cnt   <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            rf_we_o    <= 1'b0;
            rf_waddr_o <= '0;
            rf_wdata_o <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            rf_we_o <= grant_pipe | grant_head;
            if (grant_pipe) begin
                rf_waddr_o <= pipe_rd_i;
                rf_wdata_o <= pipe_data_i;
            end else if (grant_head) begin
                rf_waddr_o <= q_rd[rd_ptr];
                rf_wdata_o <= q_data[rd_ptr];
            end
        end
    end

    // Queue storage carries no reset; count gates every read of it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (grant_pipe && q_rd[i] == pipe_rd_i)
                q_live[i] <= 1'b0;
        end
        if (push) begin
            q_live[wr_ptr] <= ~push_killed;
            q_rd[wr_ptr]   <= llu_rd_i;
            q_data[wr_ptr] <= llu_data_i;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboarded directed bench for wb_port_arbiter: expected rf writes are queued
// at stimulus time and checked by a monitor whenever rf_we_o is seen.
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pipe_we_i;
    logic [4:0]  pipe_rd_i;
    logic [31:0] pipe_data_i;
    logic        llu_valid_i;
    logic [4:0]  llu_rd_i;
    logic [31:0] llu_data_i;
    logic        llu_ready_o;
    logic        stall_o;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic [1:0]  llu_pending_o;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    wb_port_arbiter #(.DATA_W(32), .RADDR_W(5), .DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .pipe_we_i(pipe_we_i), .pipe_rd_i(pipe_rd_i), .pipe_data_i(pipe_data_i),
        .llu_valid_i(llu_valid_i), .llu_rd_i(llu_rd_i), .llu_data_i(llu_data_i),
        .llu_ready_o(llu_ready_o), .stall_o(stall_o), .rf_we_o(rf_we_o),
        .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o), .llu_pending_o(llu_pending_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pipe(input logic we, input logic [4:0] rd, input logic [31:0] d);
        pipe_we_i = we; pipe_rd_i = rd; pipe_data_i = d;
    endtask

    task automatic llu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        llu_valid_i = v; llu_rd_i = rd; llu_data_i = d;
    endtask

    task automatic expect_wr(input logic [4:0] rd, input logic [31:0] d);
        exp_q.push_back('{rd: rd, data: d});
    endtask

    // Monitor: every observed rf write must match the oldest expected one.
    always @(negedge clk) begin
        if (rst_n && rf_we_o) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got rd=%0d data=0x%0h, expected no write",
                         rf_waddr_o, rf_wdata_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rf_waddr", 32'(rf_waddr_o), 32'(e.rd));
                check("rf_wdata", rf_wdata_o, e.data);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        pipe(1'b0, 5'd0, 32'd0);
        llu(1'b0, 5'd0, 32'd0);
        #23;
        check("reset_rf_we", 32'(rf_we_o), 32'd0);
        check("reset_waddr", 32'(rf_waddr_o), 32'd0);
        check("reset_wdata", rf_wdata_o, 32'd0);
        check("reset_stall", 32'(stall_o), 32'd0);
        check("reset_pending", 32'(llu_pending_o), 32'd0);
        check("reset_ready", 32'(llu_ready_o), 32'd1);
        rst_n = 1'b1;
        step();

        // Pipe only
        pipe(1'b1, 5'd5, 32'hA5A5A5A5);
        expect_wr(5'd5, 32'hA5A5A5A5);
        step();
        check("t1_stall", 32'(stall_o), 32'd0);
        pipe(1'b0, 5'd0, 32'd0);
        step();

        // LLU with idle pipe
        llu(1'b1, 5'd7, 32'h11);
        expect_wr(5'd7, 32'h11);
        step();
        llu(1'b0, 5'd0, 32'd0);
        check("t2_pending_1", 32'(llu_pending_o), 32'd1);
        step();
        check("t2_pending_0", 32'(llu_pending_o), 32'd0);
        step();

        // Starvation: head rd=3 waits four cycles behind pipe writes rd=10..13
        llu(1'b1, 5'd3, 32'h33);
        pipe(1'b1, 5'd9, 32'h909);
        expect_wr(5'd9, 32'h909);
        step();
        llu(1'b0, 5'd0, 32'd0);
        for (int r = 10; r <= 13; r++) begin
            pipe(1'b1, 5'(r), 32'(r * 32'h101));
            expect_wr(5'(r), 32'(r * 32'h101));
            check("t3_no_stall_yet", 32'(stall_o), 32'd0);
            step();
        end
        pipe(1'b1, 5'd14, 32'hE0E);
        check("t3_stall", 32'(stall_o), 32'd1);
        expect_wr(5'd3, 32'h33);
        step();
        check("t3_stall_drop", 32'(stall_o), 32'd0);
        expect_wr(5'd14, 32'hE0E);
        step();
        pipe(1'b0, 5'd0, 32'd0);
        step();

        // Full queue with busy pipe
        llu(1'b1, 5'd1, 32'h100);
        pipe(1'b1, 5'd20, 32'h20);
        expect_wr(5'd20, 32'h20);
        step();
        check("t4_ready_one", 32'(llu_ready_o), 32'd1);
        llu(1'b1, 5'd2, 32'h200);
        pipe(1'b1, 5'd21, 32'h21);
        expect_wr(5'd21, 32'h21);
        step();
        check("t4_ready_full", 32'(llu_ready_o), 32'd0);
        llu(1'b1, 5'd6, 32'h600);
        pipe(1'b1, 5'd22, 32'h22);
        expect_wr(5'd22, 32'h22);
        step();
        check("t4_still_full", 32'(llu_ready_o), 32'd0);
        check("t4_pending_2", 32'(llu_pending_o), 32'd2);
        pipe(1'b0, 5'd0, 32'd0);
        expect_wr(5'd1, 32'h100);
        step();
        check("t4_ready_after_pop", 32'(llu_ready_o), 32'd1);
        check("t4_pending_1", 32'(llu_pending_o), 32'd1);
        expect_wr(5'd2, 32'h200);
        step();
        llu(1'b0, 5'd0, 32'd0);
        check("t4_pending_swap", 32'(llu_pending_o), 32'd1);
        expect_wr(5'd6, 32'h600);
        step();
        check("t4_pending_0", 32'(llu_pending_o), 32'd0);
        step();

        // WAW kill: queued rd=4 overtaken by pipe write to rd=4
        llu(1'b1, 5'd4, 32'hDEAD);
        step();
        llu(1'b0, 5'd0, 32'd0);
        pipe(1'b1, 5'd4, 32'h4444);
        expect_wr(5'd4, 32'h4444);
        step();
        pipe(1'b0, 5'd0, 32'd0);
        check("t5_pending_killed", 32'(llu_pending_o), 32'd1);
        step();
        check("t5_pending_0", 32'(llu_pending_o), 32'd0);
        step();
        step();

        // rd==0 on both sides; LLU head uses the slot the pipe leaves unused
        pipe(1'b1, 5'd0, 32'hBAD);
        llu(1'b1, 5'd0, 32'h999);
        step();
        check("t6_pending_rd0", 32'(llu_pending_o), 32'd0);
        llu(1'b1, 5'd8, 32'h88);
        step();
        llu(1'b0, 5'd0, 32'd0);
        expect_wr(5'd8, 32'h88);
        step();
        step();
        check("t6_pending_0", 32'(llu_pending_o), 32'd0);
        pipe(1'b0, 5'd0, 32'd0);
        step();

        // Async reset while in FORCE
        llu(1'b1, 5'd15, 32'hF);
        pipe(1'b1, 5'd16, 32'h16);
        expect_wr(5'd16, 32'h16);
        step();
        llu(1'b0, 5'd0, 32'd0);
        for (int r = 17; r <= 20; r++) begin
            pipe(1'b1, 5'(r), 32'(r));
            if (r < 20) expect_wr(5'(r), 32'(r));
            step();
        end
        check("t7_in_force", 32'(stall_o), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t7_rst_stall", 32'(stall_o), 32'd0);
        check("t7_rst_we", 32'(rf_we_o), 32'd0);
        check("t7_rst_waddr", 32'(rf_waddr_o), 32'd0);
        check("t7_rst_wdata", rf_wdata_o, 32'd0);
        check("t7_rst_pending", 32'(llu_pending_o), 32'd0);
        pipe(1'b0, 5'd0, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        step();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
